// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared FSM state encoding and defaults for the receive byte sequencer
package rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_LOAD,
        ST_DONE,
        ST_ERROR
    } rx_state_t;

    localparam logic [7:0] RX_SYNC_BYTE = 8'h80;

    function automatic logic [6:0] sat_inc7(input logic [6:0] value, input logic [6:0] limit);
        return (value >= limit) ? limit : value + 7'd1;
    endfunction

endpackage

// File: rtl/rx_byte_sequencer.sv
// rtl/rx_byte_sequencer.sv - receive byte sequencer: sync detect, byte framing, handoff
//
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   bit_strobe, eop       one-cycle pulse per bit period, end-of-packet level
//   rcv_data              parallel view of the external receive shift register
//   shift_enable          shift command to that shift register
//   byte_data/byte_valid  received byte handoff, accepted with byte_ready
//   packet_done           one-cycle pulse on a clean packet end
//   rx_error              high while in the error state
//   byte_count            data bytes loaded in the current packet (saturating)
module rx_byte_sequencer
    import rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = RX_SYNC_BYTE,
    parameter int         MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       bit_strobe,
    input  logic       eop,
    input  logic [7:0] rcv_data,
    output logic       shift_enable,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       packet_done,
    output logic       rx_error,
    output logic [6:0] byte_count
);

    localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

    rx_state_t  r_state;
    logic [2:0] r_bit_cnt;
    logic       r_sync_chk;
    logic [7:0] r_byte_data;
    logic       r_byte_valid;
    logic [6:0] r_byte_count;
    logic       w_shift_state;
    logic       w_shift_enable;

    // The strobe that wakes the block from IDLE is itself the first sync
    // bit, so it is shifted and counted like every following bit.
    assign w_shift_state  = (r_state == ST_IDLE) || (r_state == ST_SYNC) || (r_state == ST_DATA);
    assign w_shift_enable = n_rst && bit_strobe && !eop && w_shift_state;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= 3'd0;
            r_sync_chk   <= 1'b0;
            r_byte_data  <= 8'h00;
            r_byte_valid <= 1'b0;
            r_byte_count <= 7'd0;
        end else begin
            if (w_shift_enable) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (r_byte_valid && byte_ready) begin
                r_byte_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_shift_enable) begin
                        r_state      <= ST_SYNC;
                        r_sync_chk   <= 1'b0;
                        r_byte_count <= 7'd0;
                    end
                end
                ST_SYNC: begin
                    // rcv_data only holds the full sync byte one cycle after
                    // the eighth shift, so the compare is deferred by a cycle.
                    if (r_sync_chk) begin
                        r_sync_chk <= 1'b0;
                        r_state    <= (rcv_data == SYNC_BYTE) ? ST_DATA : ST_ERROR;
                    end else if (w_shift_enable && (r_bit_cnt == 3'd7)) begin
                        r_sync_chk <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_shift_enable && (r_bit_cnt == 3'd7)) begin
                        r_state <= ST_LOAD;
                    end else if (eop) begin
                        r_state <= (r_bit_cnt == 3'd0) ? ST_DONE : ST_ERROR;
                    end
                end
                ST_LOAD: begin
                    if (r_byte_valid && !byte_ready) begin
                        // Overflow: the unaccepted byte is preserved.
                        r_state <= ST_ERROR;
                    end else begin
                        r_byte_data  <= rcv_data;
                        r_byte_valid <= 1'b1;
                        r_byte_count <= sat_inc7(r_byte_count, MAX_CNT);
                        r_state      <= ST_DATA;
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_bit_cnt <= 3'd0;
                end
                ST_ERROR: begin
                    if (eop) begin
                        r_state   <= ST_IDLE;
                        r_bit_cnt <= 3'd0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign shift_enable = w_shift_enable;
    assign byte_data    = r_byte_data;
    assign byte_valid   = r_byte_valid;
    assign byte_count   = r_byte_count;
    assign packet_done  = (r_state == ST_DONE);
    assign rx_error     = (r_state == ST_ERROR);

endmodule
